// File: rtl/register_file.sv
// register_file: four-entry architectural register file with ALU write-back and a flags latch.
// Optional handshaked host/debug port compiled in when REGFILE_HOST_PORT_EN is defined.
module register_file #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wb_en,
  input  logic [NUM_REGS-1:0]              regs_we,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_inp,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  regs_oup,
  input  logic [7:0]                       alu_status,
  output logic [7:0]                       flags,
  input  logic                             host_req,
  input  logic                             host_wr,
  input  logic [1:0]                       host_addr,
  input  logic [DATA_W-1:0]                host_wdata,
  output logic                             host_ack,
  output logic [DATA_W-1:0]                host_rdata,
  output logic                             host_busy
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [7:0]                      flags_q, flags_d;

  // Host write request into the register array; only ever raised while wb_en is low.
  logic              host_we;
  logic [1:0]        host_waddr;
  logic [DATA_W-1:0] host_wval;

`ifdef REGFILE_HOST_PORT_EN

  typedef enum logic [1:0] {StIdle, StPend, StDone} host_state_e;

  host_state_e       state_q, state_d;
  logic              cap_wr_q, cap_wr_d;
  logic [1:0]        cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    cap_wr_d    = cap_wr_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    rdata_d     = rdata_q;
    host_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (host_req) begin
          cap_wr_d    = host_wr;
          cap_addr_d  = host_addr;
          cap_wdata_d = host_wdata;
          state_d     = StPend;
        end
      end
      StPend: begin
        // ALU write-back owns the array this cycle; retry on the next one.
        if (!wb_en) begin
          if (cap_wr_q) begin
            host_we = 1'b1;
          end else begin
            rdata_d = regs_q[cap_addr_q];
          end
          state_d = StDone;
        end
      end
      StDone: begin
        if (!host_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cap_wr_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cap_wr_q    <= cap_wr_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign host_waddr = cap_addr_q;
  assign host_wval  = cap_wdata_q;
  assign host_ack   = (state_q == StDone);
  assign host_busy  = (state_q != StIdle);
  assign host_rdata = rdata_q;

`else

  logic unused_host;
  assign unused_host = ^{host_req, host_wr, host_addr, host_wdata};

  assign host_we    = 1'b0;
  assign host_waddr = '0;
  assign host_wval  = '0;
  assign host_ack   = 1'b0;
  assign host_busy  = 1'b0;
  assign host_rdata = '0;

`endif

  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    if (wb_en) begin
      flags_d = alu_status;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (regs_we[i]) begin
          regs_d[i] = regs_inp[i];
        end
      end
    end
    if (host_we) begin
      regs_d[host_waddr] = host_wval;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '0;
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  // Outputs come straight from flops, so the ALU loop never closes combinationally.
  assign regs_oup = regs_q;
  assign flags    = flags_q;

endmodule

// File: doc/register_file.md
# register_file

Four-entry, 8-bit architectural register file at the far end of the ALU register interface: it presents every register value on `regs_oup`, commits `regs_inp` on one-hot `regs_we` when the ALU write-back strobe is high, and latches `alu_status` into a flags register. An optional host/debug port gives handshaked read and write access to any register. ALU write-back always has priority over host access.

## Interface
Parameters:
- `NUM_REGS`, 4, number of registers; fixed at 4 (2-bit addresses).
- `DATA_W`, 8, register and data width.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `wb_en`  input  1  ALU write-back strobe (ALU `alu_en`); qualifies `regs_we` and `alu_status`.
- `regs_we`  input  NUM_REGS  per-register write enable from the ALU.
- `regs_inp`  input  DATA_W x NUM_REGS  per-register write data from the ALU.
- `regs_oup`  output  DATA_W x NUM_REGS  current register contents, directly from flops.
- `alu_status`  input  8  ALU status byte; bit 0 is zero.
- `flags`  output  8  latched ALU status.
- `host_req`  input  1  host access request; held until `host_ack`.
- `host_wr`  input  1  1 = write, 0 = read; sampled with the request.
- `host_addr`  input  2  register index.
- `host_wdata`  input  DATA_W  write data.
- `host_ack`  output  1  access complete; held high until `host_req` falls.
- `host_rdata`  output  DATA_W  read data, valid while `host_ack`=1.
- `host_busy`  output  1  high when the host FSM is not in IDLE.

## Operation
- ALU write: at each edge with `wb_en`=1, every register i with `regs_we[i]`=1 loads `regs_inp[i]`. Multiple set bits write multiple registers in the same edge. Non-0/1 values on `regs_we` are treated as 0.
- Flags: at each edge with `wb_en`=1, `flags` loads `alu_status`, independent of `regs_we`. This covers compare operations that write no register.
- `regs_we` and `regs_inp` are ignored when `wb_en`=0.
- `regs_oup` is purely registered. There is no combinational path from `regs_inp` to `regs_oup`, so the ALU-to-register-file loop never forms a combinational loop.
- Host FSM states:
  - IDLE: if `host_req`=1, capture `host_wr`, `host_addr` and `host_wdata`, then go to PEND.
  - PEND: if `wb_en`=1, stay (stall). Otherwise perform the access at this edge, set `host_ack`=1, go to DONE.
    - Read: `host_rdata` is the register value before this edge.
    - Write: the addressed register loads the captured write data.
  - DONE: hold `host_ack`=1 and `host_rdata`. When `host_req`=0, clear `host_ack` and go to IDLE.
- Host writes only happen in cycles with `wb_en`=0, so host and ALU writes never collide.
- Request fields are captured in IDLE. Changes to `host_wr`, `host_addr` or `host_wdata` after capture have no effect.

## Timing
- Reset (async assert, sync-released deassert at the user's side) gives:
  - all registers = 0 and `flags` = 0;
  - FSM in IDLE, `host_ack`=0, `host_rdata`=0, `host_busy`=0.
- ALU write latency: data is visible on `regs_oup` and `flags` one cycle after the `wb_en` edge.
- Host latency with no stall: `host_req` rises before edge 0. Edge 0 moves to PEND, edge 1 performs the access, so `host_ack`=1 after edge 1. Each `wb_en`=1 cycle in PEND adds one cycle.
- Back-to-back host access: a new request is accepted only after `host_ack` falls. Minimum 3 cycles per access.
- `wb_en` held high indefinitely stalls the host indefinitely. This is by design; ALU priority is absolute.
- Reset mid-access (PEND or DONE): the pending access is discarded with no register write, and `host_ack` drops immediately.

## Configuration
- `REGFILE_HOST_PORT_EN` defined: the host FSM and port are compiled in as described above.
- Not defined: the host FSM is removed.
  - `host_ack`, `host_rdata` and `host_busy` are tied to 0.
  - Host inputs are ignored.
  - Only the ALU writes registers.

## Test plan
- Reset, then release: all `regs_oup`=0x00, `flags`=0x00, `host_ack`=0.
- `wb_en`=1, `regs_we`=4'b0100, `regs_inp[2]`=0x5A, `alu_status`=0x00 -> after the edge, reg2=0x5A, other registers unchanged, `flags`=0x00. Then `wb_en`=0 with `regs_we`=4'b1111 -> no change.
- `wb_en`=1, `regs_we`=0, `alu_status`=0x01 (compare) -> `flags`=0x01 and all registers unchanged.
- Host write addr 3, data 0xC3, `wb_en`=0 -> `host_ack` after 2 edges, reg3=0xC3. Then host read addr 3 -> `host_rdata`=0xC3. `host_ack` holds until `host_req` drops, then returns to 0.
- Host read addr 1 (reg1=0x11) issued while `wb_en`=1 for 3 cycles and writing reg1=0x22 -> ack delayed by 3 cycles, `host_rdata`=0x22.
- Host write in PEND, then `rst_n` pulsed low -> target register stays 0x00, `host_ack`=0, `host_busy`=0. With `REGFILE_HOST_PORT_EN` undefined, `host_req`=1 never produces `host_ack`.
